// File: rtl/sdpb_line_pingpong_if.sv
// ----------------------------------------------------------------------------
// sdpb_line_pingpong_if
//   Bundles the pixel write stream, the line read stream and both SDPB RAM
//   ports of the ping-pong line-buffer controller.
//   slave  : controller side (drives wr_ready, rd_*, bank_swap, RAM controls)
//   master : environment side (drives wr_valid/wr_data/wr_last, rd_start,
//            ram_dout)
// ----------------------------------------------------------------------------
interface sdpb_line_pingpong_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          wr_ready;
    logic          rd_start;
    logic          rd_busy;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          bank_swap;
    logic          ram_cea;
    logic [AW-1:0] ram_ada;
    logic [DW-1:0] ram_din;
    logic          ram_ceb;
    logic          ram_oce;
    logic [AW-1:0] ram_adb;
    logic [DW-1:0] ram_dout;

    modport master (
        output wr_valid, wr_data, wr_last, rd_start, ram_dout,
        input  wr_ready, rd_busy, rd_valid, rd_data, rd_last, bank_swap,
        input  ram_cea, ram_ada, ram_din, ram_ceb, ram_oce, ram_adb
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, rd_start, ram_dout,
        output wr_ready, rd_busy, rd_valid, rd_data, rd_last, bank_swap,
        output ram_cea, ram_ada, ram_din, ram_ceb, ram_oce, ram_adb
    );
endinterface

// File: rtl/sdpb_line_pingpong.sv
// ----------------------------------------------------------------------------
// sdpb_line_pingpong
//   Ping-pong line-buffer controller for one simple dual-port block RAM.
//   The RAM is split into two banks of LINE_WORDS words; incoming pixel
//   words fill the write bank while the read side drains the other bank.
//   Banks swap only when the read side is idle and empty, so a bank is never
//   written while it is being read.
// Ports
//   clk    : single clock for both RAM ports
//   reset  : asynchronous, active-high
//   bus    : sdpb_line_pingpong_if.slave (write stream, read stream, RAM A/B)
// ----------------------------------------------------------------------------
module sdpb_line_pingpong #(
    parameter int unsigned LINE_WORDS   = 16,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    sdpb_line_pingpong_if.slave    bus
);
    localparam int unsigned AW = $clog2(2 * LINE_WORDS);
    // Wide enough to hold a length of LINE_WORDS, not just an index.
    localparam int unsigned LW = $clog2(LINE_WORDS + 1);

    typedef enum logic {WFill, WWait} wr_state_e;
    typedef enum logic [1:0] {RIdle, RIssue, RDrain} rd_state_e;

    wr_state_e               r_wr_state;
    rd_state_e               r_rd_state;
    logic                    r_wr_bank;
    logic                    r_rd_full;
    logic [LW-1:0]           r_wr_ptr;
    logic [LW-1:0]           r_wr_len;
    logic [LW-1:0]           r_rd_ptr;
    logic [LW-1:0]           r_rd_len;
    logic [1:0]              r_drain_cnt;
    logic [READ_LATENCY-1:0] r_vld_pipe;
    logic [READ_LATENCY-1:0] r_last_pipe;

    logic                  w_wr_ready;
    logic                  w_wr_accept;
    logic                  w_wr_end;
    logic                  w_swap;
    logic                  w_rd_issue;
    logic                  w_rd_final;
    logic [AW-1:0]         w_wr_base;
    logic [AW-1:0]         w_rd_base;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Gated by reset so the port shows 0 for the whole reset pulse.
    assign w_wr_ready  = (r_wr_state == WFill) && !reset;
    assign w_wr_accept = bus.wr_valid && w_wr_ready;
    // A line ends on wr_last or when the bank is full.
    assign w_wr_end    = bus.wr_last || (r_wr_ptr == LW'(LINE_WORDS - 1));
    assign w_swap      = (r_wr_state == WWait) && !r_rd_full && (r_rd_state == RIdle);
    assign w_rd_issue  = (r_rd_state == RIssue);
    assign w_rd_final  = w_rd_issue && (r_rd_ptr == r_rd_len - LW'(1));
    assign w_wr_base   = r_wr_bank ? AW'(LINE_WORDS) : '0;
    assign w_rd_base   = r_wr_bank ? '0 : AW'(LINE_WORDS);
    assign w_rd_data   = r_vld_pipe[READ_LATENCY-1] ? bus.ram_dout : '0;

    // Write FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_state <= WFill;
            r_wr_bank  <= 1'b0;
            r_wr_ptr   <= '0;
            r_wr_len   <= '0;
        end else begin
            unique case (r_wr_state)
                WFill: begin
                    if (w_wr_accept) begin
                        r_wr_ptr <= r_wr_ptr + LW'(1);
                        if (w_wr_end) begin
                            r_wr_len   <= r_wr_ptr + LW'(1);
                            r_wr_state <= WWait;
                        end
                    end
                end
                WWait: begin
                    if (w_swap) begin
                        r_wr_bank  <= ~r_wr_bank;
                        r_wr_ptr   <= '0;
                        r_wr_state <= WFill;
                    end
                end
                default: r_wr_state <= WFill;
            endcase
        end
    end

    // Read FSM; also owns rd_full/rd_len, which the swap loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_state  <= RIdle;
            r_rd_full   <= 1'b0;
            r_rd_ptr    <= '0;
            r_rd_len    <= '0;
            r_drain_cnt <= '0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            // Data-valid tracks the RAM read pipeline depth.
            r_vld_pipe[0]  <= w_rd_issue;
            r_last_pipe[0] <= w_rd_final;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
            if (w_swap) begin
                r_rd_full <= 1'b1;
                r_rd_len  <= r_wr_len;
            end
            unique case (r_rd_state)
                RIdle: begin
                    if (bus.rd_start && r_rd_full) begin
                        r_rd_ptr   <= '0;
                        r_rd_state <= RIssue;
                    end
                end
                RIssue: begin
                    if (w_rd_final) begin
                        r_drain_cnt <= '0;
                        r_rd_state  <= RDrain;
                    end else begin
                        r_rd_ptr <= r_rd_ptr + LW'(1);
                    end
                end
                RDrain: begin
                    if (r_drain_cnt == 2'(READ_LATENCY - 1)) begin
                        r_rd_full  <= 1'b0;
                        r_rd_state <= RIdle;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                default: r_rd_state <= RIdle;
            endcase
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.ram_cea   = w_wr_accept;
    assign bus.ram_ada   = w_wr_base + AW'(r_wr_ptr);
    assign bus.ram_din   = w_wr_accept ? bus.wr_data : '0;
    assign bus.ram_ceb   = w_rd_issue;
    assign bus.ram_oce   = (r_rd_state != RIdle);
    assign bus.ram_adb   = w_rd_issue ? (w_rd_base + AW'(r_rd_ptr)) : '0;
    assign bus.rd_busy   = (r_rd_state != RIdle);
    assign bus.rd_valid  = r_vld_pipe[READ_LATENCY-1];
    assign bus.rd_last   = r_last_pipe[READ_LATENCY-1];
    assign bus.rd_data   = w_rd_data;
    assign bus.bank_swap = w_swap;
endmodule

// File: tb/tb_sdpb_line_pingpong.sv
// Two controllers share the clock: u_dut0 with READ_LATENCY=1, u_dut1 with READ_LATENCY=2.
// Each has its own behavioural SDPB RAM and read-side scoreboard.
module tb_sdpb_line_pingpong;
    logic clk;
    logic reset;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        int          k;
        logic [31:0] data;
        logic        last;
        logic [4:0]  ada;
        logic [4:0]  rd_base;
        int          rd_len;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb0[$];
    exp_t sb1[$];
    logic [31:0] model [2][32];

    // Stimulus arrays, index = DUT number.
    logic [1:0]  wr_valid;
    logic [1:0]  wr_last;
    logic [1:0]  rd_start;
    logic [31:0] wr_data [2];

    logic [1:0]  rdy_w, cea_w, ceb_w, oce_w, busy_w, rvld_w, rlast_w, swap_w;
    logic [4:0]  ada_w [2];
    logic [4:0]  adb_w [2];
    logic [31:0] din_w [2];
    logic [31:0] rdata_w [2];

    sdpb_line_pingpong_if #(.DW(32), .AW(5)) bus0 ();
    sdpb_line_pingpong_if #(.DW(32), .AW(5)) bus1 ();

    sdpb_line_pingpong #(.LINE_WORDS(16), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );
    sdpb_line_pingpong #(.LINE_WORDS(16), .DATA_WIDTH(32), .READ_LATENCY(2)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    assign bus0.wr_valid = wr_valid[0];
    assign bus1.wr_valid = wr_valid[1];
    assign bus0.wr_last  = wr_last[0];
    assign bus1.wr_last  = wr_last[1];
    assign bus0.wr_data  = wr_data[0];
    assign bus1.wr_data  = wr_data[1];
    assign bus0.rd_start = rd_start[0];
    assign bus1.rd_start = rd_start[1];

    assign rdy_w   = {bus1.wr_ready, bus0.wr_ready};
    assign cea_w   = {bus1.ram_cea, bus0.ram_cea};
    assign ceb_w   = {bus1.ram_ceb, bus0.ram_ceb};
    assign oce_w   = {bus1.ram_oce, bus0.ram_oce};
    assign busy_w  = {bus1.rd_busy, bus0.rd_busy};
    assign rvld_w  = {bus1.rd_valid, bus0.rd_valid};
    assign rlast_w = {bus1.rd_last, bus0.rd_last};
    assign swap_w  = {bus1.bank_swap, bus0.bank_swap};
    assign ada_w[0]   = bus0.ram_ada;
    assign ada_w[1]   = bus1.ram_ada;
    assign adb_w[0]   = bus0.ram_adb;
    assign adb_w[1]   = bus1.ram_adb;
    assign din_w[0]   = bus0.ram_din;
    assign din_w[1]   = bus1.ram_din;
    assign rdata_w[0] = bus0.rd_data;
    assign rdata_w[1] = bus1.rd_data;

    // SDPB RAM models: latency 1 (registered read) and latency 2 (plus oce stage).
    logic [31:0] mem0 [32];
    logic [31:0] mem1 [32];
    logic [31:0] d0, d1a, d1b;
    always @(posedge clk) begin
        if (bus0.ram_cea) mem0[bus0.ram_ada] <= bus0.ram_din;
        if (bus0.ram_ceb) d0 <= mem0[bus0.ram_adb];
        if (bus1.ram_cea) mem1[bus1.ram_ada] <= bus1.ram_din;
        if (bus1.ram_ceb) d1a <= mem1[bus1.ram_adb];
        if (bus1.ram_oce) d1b <= d1a;
    end
    assign bus0.ram_dout = d0;
    assign bus1.ram_dout = d1b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Read-side monitor: latency model, scoreboard pop, data gating, bank overlap.
    initial begin
        logic [1:0] hist [2];
        logic       expv;
        exp_t       e;
        hist[0] = '0;
        hist[1] = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hist[0] = '0;
                hist[1] = '0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    expv = (k == 0) ? hist[0][0] : hist[1][1];
                    check($sformatf("rd_valid_latency%0d", k), 32'(rvld_w[k]), 32'(expv));
                    if (rvld_w[k]) begin
                        if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL sb_underflow%0d: got rd_valid=1, required no read pending", k);
                        end else begin
                            e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                            check($sformatf("rd_data%0d", k), rdata_w[k], e.data);
                            check($sformatf("rd_last%0d", k), 32'(rlast_w[k]), 32'(e.last));
                        end
                    end else begin
                        check($sformatf("rd_data_gated%0d", k), rdata_w[k], 32'h0);
                    end
                    if (cea_w[k] && ceb_w[k]) begin
                        check($sformatf("bank_overlap%0d", k),
                              32'(ada_w[k][4] == adb_w[k][4]), 32'h0);
                    end
                    hist[k] = {hist[k][0], ceb_w[k]};
                end
            end
        end
    end

    task automatic write_word(input int k, input logic [31:0] data, input logic last,
                              input logic [4:0] ada);
        int waited = 0;
        @(negedge clk);
        while (!rdy_w[k] && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("wr_ready_wait%0d", k), 32'(rdy_w[k]), 32'h1);
        wr_valid[k] = 1'b1;
        wr_data[k]  = data;
        wr_last[k]  = last;
        #1;
        check($sformatf("ram_cea%0d", k), 32'(cea_w[k]), 32'h1);
        check($sformatf("ram_ada%0d", k), 32'(ada_w[k]), 32'(ada));
        check($sformatf("ram_din%0d", k), din_w[k], data);
        model[k][ada] = data;
        @(posedge clk);
        #1;
        wr_valid[k] = 1'b0;
        wr_last[k]  = 1'b0;
    endtask

    task automatic check_swap(input int k);
        @(negedge clk);
        check($sformatf("swap_wr_ready_low%0d", k), 32'(rdy_w[k]), 32'h0);
        check($sformatf("bank_swap%0d", k), 32'(swap_w[k]), 32'h1);
        @(negedge clk);
        check($sformatf("post_swap_wr_ready%0d", k), 32'(rdy_w[k]), 32'h1);
        check($sformatf("bank_swap_pulse%0d", k), 32'(swap_w[k]), 32'h0);
    endtask

    // Called on a negedge; pushes the expected line and pulses rd_start.
    task automatic start_read(input int k, input logic [4:0] base, input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.data = model[k][int'(base) + i];
            e.last = (i == len - 1);
            if (k == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        rd_start[k] = 1'b1;
        @(posedge clk);
        #1;
        rd_start[k] = 1'b0;
    endtask

    // Returns on the first negedge with rd_busy low.
    task automatic do_read(input int k, input logic [4:0] base, input int len);
        int n = 0;
        start_read(k, base, len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check($sformatf("ram_ceb%0d", k), 32'(ceb_w[k]), 32'h1);
            check($sformatf("ram_adb%0d", k), 32'(adb_w[k]), 32'(int'(base) + i));
        end
        @(negedge clk);
        while (busy_w[k] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("rd_busy_fall%0d", k), 32'(busy_w[k]), 32'h0);
        check($sformatf("sb_empty%0d", k), (k == 0) ? sb0.size() : sb1.size(), 32'h0);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        // Line 1 (16 words) and line 2 (5 words) on u_dut0, then a 16-word line on u_dut1.
        for (int i = 0; i < 16; i++) begin
            v = '{0, 32'hDEADBEEF ^ 32'(i), (i == 15), 5'(i), 5'd0, 16};
            vecs.push_back(v);
        end
        for (int i = 0; i < 5; i++) begin
            v = '{0, 32'h1234_0000 + 32'(i), (i == 4), 5'(16 + i), 5'd16, 5};
            vecs.push_back(v);
        end
        for (int i = 0; i < 16; i++) begin
            v = '{1, 32'hA5A5_0000 + 32'(i * 3), (i == 15), 5'(i), 5'd0, 16};
            vecs.push_back(v);
        end

        reset    = 1'b1;
        wr_valid = '0;
        wr_last  = '0;
        rd_start = '0;
        wr_data[0] = '0;
        wr_data[1] = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_wr_ready%0d", k), 32'(rdy_w[k]), 32'h0);
            check($sformatf("rst_rd_busy%0d", k), 32'(busy_w[k]), 32'h0);
            check($sformatf("rst_ceb%0d", k), 32'(ceb_w[k] | oce_w[k]), 32'h0);
            check($sformatf("rst_rd_valid%0d", k), 32'(rvld_w[k]), 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("rel_wr_ready0", 32'(rdy_w[0]), 32'h1);
        check("rel_wr_ready1", 32'(rdy_w[1]), 32'h1);

        foreach (vecs[i]) begin
            write_word(vecs[i].k, vecs[i].data, vecs[i].last, vecs[i].ada);
            if (vecs[i].last) begin
                check_swap(vecs[i].k);
                do_read(vecs[i].k, vecs[i].rd_base, vecs[i].rd_len);
            end
        end

        // Second line written while the first is unread: W_WAIT until the drain ends.
        for (int i = 0; i < 4; i++) write_word(0, 32'h3300_0000 + 32'(i), (i == 3), 5'(i));
        check_swap(0);
        for (int i = 0; i < 3; i++) write_word(0, 32'h4400_0000 + 32'(i), (i == 2), 5'(16 + i));
        repeat (5) begin
            @(negedge clk);
            check("wait_wr_ready", 32'(rdy_w[0]), 32'h0);
            check("wait_no_swap", 32'(swap_w[0]), 32'h0);
        end
        do_read(0, 5'd0, 4);
        check("late_swap", 32'(swap_w[0]), 32'h1);
        check("late_swap_wr_ready", 32'(rdy_w[0]), 32'h0);
        @(negedge clk);
        check("after_late_swap_ready", 32'(rdy_w[0]), 32'h1);
        do_read(0, 5'd16, 3);

        // rd_start with nothing buffered is ignored.
        rd_start[0] = 1'b1;
        @(posedge clk);
        #1;
        rd_start[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("empty_start_busy", 32'(busy_w[0]), 32'h0);
            check("empty_start_ceb", 32'(ceb_w[0]), 32'h0);
            check("empty_start_valid", 32'(rvld_w[0]), 32'h0);
        end

        // Reset in the middle of a read issue and a line fill.
        for (int i = 0; i < 16; i++) write_word(0, 32'h5500_0000 + 32'(i), (i == 15), 5'(i));
        check_swap(0);
        start_read(0, 5'd0, 16);
        write_word(0, 32'h6600_0000, 1'b0, 5'd16);
        write_word(0, 32'h6600_0001, 1'b0, 5'd17);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_wr_ready", 32'(rdy_w[0]), 32'h0);
        check("mid_rst_ceb", 32'(ceb_w[0]), 32'h0);
        check("mid_rst_oce", 32'(oce_w[0]), 32'h0);
        check("mid_rst_busy", 32'(busy_w[0]), 32'h0);
        check("mid_rst_valid", 32'(rvld_w[0]), 32'h0);
        check("mid_rst_last", 32'(rlast_w[0]), 32'h0);
        check("mid_rst_swap", 32'(swap_w[0]), 32'h0);
        check("mid_rst_adb", 32'(adb_w[0]), 32'h0);
        sb0.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_wr_ready", 32'(rdy_w[0]), 32'h1);
        rd_start[0] = 1'b1;
        @(posedge clk);
        #1;
        rd_start[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_start_busy", 32'(busy_w[0]), 32'h0);
            check("post_rst_start_ceb", 32'(ceb_w[0]), 32'h0);
        end
        write_word(0, 32'h7700_0077, 1'b1, 5'd0);
        check_swap(0);
        do_read(0, 5'd0, 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
